mul_pipeline_param: RTL and testbench

//   Parametrised pipelined shift-add multiplier, successor to the fixed 8-bit unit.

---
 rtl/mul_pipe_pkg.sv | 31 +++
 rtl/mul_pp_stage.sv | 87 ++++++++
 rtl/mul_pipeline_param.sv | 176 +++++++++++++++++
 tb/tb_mul_pipeline_param.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_pkg.sv
// Shared definitions for the parametrised shift-add multiplier pipeline.
// Latency: n/a (package). Backpressure: n/a.
// Contents: operand mode encoding, pipeline latency and stage-record field widths.
package mul_pipe_pkg;

    // Per-transaction operand interpretation.
    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

    // Clock edges from accept to result on p_o with no stalls.
    function automatic int mul_latency(input int width);
        return width;
    endfunction

    // Stage-record field widths, so integrators can size taps and monitors.
    function automatic int stage_acc_w(input int width);
        return 2 * width;
    endfunction

    function automatic int stage_opnd_w(input int width);
        return width;
    endfunction

    // Counter must hold WIDTH+1 (S0..S_WIDTH all valid).
    function automatic int stage_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/mul_pp_stage.sv
// One shift-add stage S_K: adds (or, for the signed top bit, subtracts) partial product K.
// Latency: 1 cycle. Backpressure: all registers hold while en=0; clear drops the valid bit.
// Ports: clk, rst_n, en (=~stall), clear (flush), i_* upstream stage record, o_* registered record.
module mul_pp_stage
    import mul_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int K     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 i_vld,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic                 i_mode,
    output logic                 o_vld,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic [WIDTH-1:0]     o_a,
    output logic [WIDTH-1:0]     o_b,
    output logic [TAG_W-1:0]     o_tag,
    output logic                 o_mode
);

    logic                 r_vld;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_mode;

    logic [2*WIDTH-1:0]   w_ext_a;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_sum;

    always_comb begin
        w_ext_a = {{WIDTH{1'b0}}, i_a};
        if (i_mode == MODE_SIGNED) begin
            w_ext_a = {{WIDTH{i_a[WIDTH-1]}}, i_a};
        end
        w_pp = i_b[K] ? (w_ext_a << K) : '0;
        // In two's complement the multiplier MSB carries weight -2^(WIDTH-1),
        // so its partial product is subtracted rather than added.
        if ((K == WIDTH - 1) && (i_mode == MODE_SIGNED)) begin
            w_sum = i_acc - w_pp;
        end else begin
            w_sum = i_acc + w_pp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_tag  <= '0;
            r_mode <= 1'b0;
        end else begin
            if (clear) begin
                r_vld <= 1'b0;
            end else if (en) begin
                r_vld <= i_vld;
            end
            // Data follows en only; a flushed stage's data is ignored because valid is 0.
            if (en) begin
                r_acc  <= w_sum;
                r_a    <= i_a;
                r_b    <= i_b;
                r_tag  <= i_tag;
                r_mode <= i_mode;
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_acc  = r_acc;
    assign o_a    = r_a;
    assign o_b    = r_b;
    assign o_tag  = r_tag;
    assign o_mode = r_mode;

endmodule

// File: rtl/mul_pipeline_param.sv
// Pipelined shift-add multiplier, full 2*WIDTH product, unsigned or signed per pair, tag passthrough.
// Latency: WIDTH cycles accept-to-result; one result per clock when unstalled.
// Backpressure: valid_o & ~ready_i freezes every stage; ready_o = ~stall & ~flush_i (comb from ready_i).
// Ports: clk, rst_n; upstream valid_i/ready_o/a_i/b_i/signed_i/tag_i; flush_i;
//        downstream valid_o/ready_i/p_o/tag_o; in_flight_o = number of valid stages S0..S_WIDTH.
module mul_pipeline_param
    import mul_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH-1:0]              a_i,
    input  logic [WIDTH-1:0]              b_i,
    input  logic                          signed_i,
    input  logic [TAG_W-1:0]              tag_i,
    input  logic                          flush_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [2*WIDTH-1:0]            p_o,
    output logic [TAG_W-1:0]              tag_o,
    output logic [$clog2(WIDTH+2)-1:0]    in_flight_o
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    // Handshake
    logic w_stall;
    logic w_en;
    logic w_accept;
    logic w_xfer;

    // S0 registers
    logic                 r_s0_vld;
    logic [2*WIDTH-1:0]   r_s0_acc;
    logic [WIDTH-1:0]     r_s0_a;
    logic [WIDTH-1:0]     r_s0_b;
    logic [TAG_W-1:0]     r_s0_tag;
    logic                 r_s0_mode;
    logic [2*WIDTH-1:0]   w_ext_a0;
    logic [2*WIDTH-1:0]   w_pp0;

    // Stage chain: index k is the output of S_k (index 0 is S0).
    logic                 w_vld  [WIDTH];
    logic [2*WIDTH-1:0]   w_acc  [WIDTH];
    logic [WIDTH-1:0]     w_a    [WIDTH];
    logic [WIDTH-1:0]     w_b    [WIDTH];
    logic [TAG_W-1:0]     w_tag  [WIDTH];
    logic                 w_mode [WIDTH];

    // Output stage S_WIDTH and occupancy counter
    logic                 r_out_vld;
    logic [2*WIDTH-1:0]   r_out_p;
    logic [TAG_W-1:0]     r_out_tag;
    logic [CNT_W-1:0]     r_cnt;

    assign w_stall  = r_out_vld & ~ready_i;
    assign w_en     = ~w_stall;
    assign ready_o  = ~w_stall & ~flush_i;
    assign w_accept = valid_i & ready_o;
    // A transfer in the flush cycle still counts as delivered.
    assign w_xfer   = r_out_vld & ready_i;

    // S0: partial product 0 goes straight into the accumulator.
    always_comb begin
        w_ext_a0 = {{WIDTH{1'b0}}, a_i};
        if (signed_i == MODE_SIGNED) begin
            w_ext_a0 = {{WIDTH{a_i[WIDTH-1]}}, a_i};
        end
        w_pp0 = b_i[0] ? w_ext_a0 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_vld  <= 1'b0;
            r_s0_acc  <= '0;
            r_s0_a    <= '0;
            r_s0_b    <= '0;
            r_s0_tag  <= '0;
            r_s0_mode <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s0_vld <= 1'b0;
            end else if (w_en) begin
                r_s0_vld <= w_accept;
            end
            if (w_en) begin
                r_s0_acc  <= w_pp0;
                r_s0_a    <= a_i;
                r_s0_b    <= b_i;
                r_s0_tag  <= tag_i;
                r_s0_mode <= signed_i;
            end
        end
    end

    assign w_vld[0]  = r_s0_vld;
    assign w_acc[0]  = r_s0_acc;
    assign w_a[0]    = r_s0_a;
    assign w_b[0]    = r_s0_b;
    assign w_tag[0]  = r_s0_tag;
    assign w_mode[0] = r_s0_mode;

    // S1..S_(WIDTH-1)
    for (genvar k = 1; k < WIDTH; k++) begin : g_stage
        mul_pp_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (w_en),
            .clear  (flush_i),
            .i_vld  (w_vld[k-1]),
            .i_acc  (w_acc[k-1]),
            .i_a    (w_a[k-1]),
            .i_b    (w_b[k-1]),
            .i_tag  (w_tag[k-1]),
            .i_mode (w_mode[k-1]),
            .o_vld  (w_vld[k]),
            .o_acc  (w_acc[k]),
            .o_a    (w_a[k]),
            .o_b    (w_b[k]),
            .o_tag  (w_tag[k]),
            .o_mode (w_mode[k])
        );
    end

    // Operands and mode are fully consumed by the last adder stage.
    logic w_unused;
    assign w_unused = ^{w_a[WIDTH-1], w_b[WIDTH-1], w_mode[WIDTH-1]};

    // S_WIDTH: registers the finished product; holds p_o/tag_o while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_p   <= '0;
            r_out_tag <= '0;
        end else begin
            if (flush_i) begin
                r_out_vld <= 1'b0;
            end else if (w_en) begin
                r_out_vld <= w_vld[WIDTH-1];
            end
            if (w_en) begin
                r_out_p   <= w_acc[WIDTH-1];
                r_out_tag <= w_tag[WIDTH-1];
            end
        end
    end

    // Occupancy: tracks valid stages without summing WIDTH+1 valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            case ({w_accept, w_xfer})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign valid_o     = r_out_vld;
    assign p_o         = r_out_p;
    assign tag_o       = r_out_tag;
    assign in_flight_o = r_cnt;

endmodule

// File: tb/tb_mul_pipeline_param.sv
module tb_mul_pipeline_param;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int W4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        v8, rdy8, s8, fl8, vo8, ri8;
    logic [7:0]  a8, b8;
    logic [3:0]  t8, to8;
    logic [15:0] p8;
    logic [3:0]  inf8;

    // WIDTH=4 instance
    logic        v4, rdy4, s4, fl4, vo4, ri4;
    logic [3:0]  a4, b4;
    logic [3:0]  t4, to4;
    logic [7:0]  p4;
    logic [2:0]  inf4;

    mul_pipeline_param #(.WIDTH(W), .TAG_W(TW)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .valid_i(v8), .ready_o(rdy8), .a_i(a8), .b_i(b8),
        .signed_i(s8), .tag_i(t8), .flush_i(fl8), .valid_o(vo8), .ready_i(ri8),
        .p_o(p8), .tag_o(to8), .in_flight_o(inf8)
    );

    mul_pipeline_param #(.WIDTH(W4), .TAG_W(TW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .valid_i(v4), .ready_o(rdy4), .a_i(a4), .b_i(b4),
        .signed_i(s4), .tag_i(t4), .flush_i(fl4), .valid_o(vo4), .ready_i(ri4),
        .p_o(p4), .tag_o(to4), .in_flight_o(inf4)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  t;
    } exp_t;

    vec_t tbl [12];
    exp_t q8 [$];
    exp_t q4 [$];

    int total = 0;
    int bad = 0;
    int n_xfer = 0;
    int cur_run = 0;
    int max_run = 0;
    int peak = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference product: plain integer multiply of the interpreted operands.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s, input int w);
        longint x, y, pr;
        x = longint'(a);
        y = longint'(b);
        if (s && a[w-1]) x = x - (longint'(1) <<< w);
        if (s && b[w-1]) y = y - (longint'(1) <<< w);
        pr = x * y;
        return pr[15:0];
    endfunction

    // Samples outputs at the falling edge (transfer happens at the next rising edge),
    // then advances past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (vo8 && ri8) begin
            n_xfer++;
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w8_unexpected: got p=%0h tag=%0h want no result", p8, to8);
            end else begin
                e = q8.pop_front();
                chk("w8_p", p8, e.p);
                chk("w8_tag", to8, e.t);
            end
        end
        if (vo4 && ri4) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w4_unexpected: got p=%0h tag=%0h want no result", p4, to4);
            end else begin
                e = q4.pop_front();
                chk("w4_p", p4, e.p);
                chk("w4_tag", to4, e.t);
            end
        end
        if (vo8) cur_run++;
        else cur_run = 0;
        if (cur_run > max_run) max_run = cur_run;
        if (int'(inf8) > peak) peak = int'(inf8);
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] t);
        v8 = 1'b1;
        a8 = a;
        b8 = b;
        s8 = s;
        t8 = t;
        step();
        v8 = 1'b0;
    endtask

    task automatic wait_vo8(input string nm);
        int n;
        n = 0;
        while (!vo8 && n < 20) begin
            step();
            n++;
        end
        chk(nm, vo8, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] hold_p;
        logic [3:0]  hold_t;
        logic [3:0]  hold_if;
        int          lat;
        int          xb;
        logic [7:0]  ra, rb;
        logic        rs;

        // a, b, signed, hand-computed product
        tbl[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        tbl[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        tbl[2]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        tbl[3]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        tbl[4]  = '{8'h00, 8'h00, 1'b0, 16'h0000};
        tbl[5]  = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};
        tbl[6]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        tbl[7]  = '{8'h80, 8'hFF, 1'b1, 16'h0080};
        tbl[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        tbl[9]  = '{8'h02, 8'h80, 1'b1, 16'hFF00};
        tbl[10] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        tbl[11] = '{8'h0A, 8'h0C, 1'b0, 16'h0078};

        v8 = 0; a8 = 0; b8 = 0; s8 = 0; t8 = 0; fl8 = 0; ri8 = 1;
        v4 = 0; a4 = 0; b4 = 0; s4 = 0; t4 = 0; fl4 = 0; ri4 = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p", p8, 16'h0);
        chk("rst_tag", to8, 4'h0);
        chk("rst_valid", vo8, 1'b0);
        chk("rst_inflight", inf8, 4'h0);
        chk("rst_ready", rdy8, 1'b1);
        rst_n = 1'b1;
        step();

        // Single unsigned 255*255: exact latency and one-cycle valid
        q8.push_back('{16'hFE01, 4'h3});
        send8(8'hFF, 8'hFF, 1'b0, 4'h3);
        lat = 13;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (vo8) begin
                lat = i;
                break;
            end
        end
        chk("t1_latency", lat, W);
        chk("t1_p", p8, 16'hFE01);
        chk("t1_tag", to8, 4'h3);
        step();
        chk("t1_one_cycle", vo8, 1'b0);

        // Back-to-back stream: directed table then random mixed-mode pairs
        max_run = 0;
        peak = 0;
        for (int j = 0; j < 12; j++) begin
            q8.push_back('{tbl[j].p, 4'(j)});
            v8 = 1'b1; a8 = tbl[j].a; b8 = tbl[j].b; s8 = tbl[j].s; t8 = 4'(j);
            step();
        end
        for (int j = 0; j < 12; j++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            q8.push_back('{ref_mul({8'h0, ra}, {8'h0, rb}, rs, W), 4'(j + 4)});
            v8 = 1'b1; a8 = ra; b8 = rb; s8 = rs; t8 = 4'(j + 4);
            step();
        end
        v8 = 1'b0;
        repeat (12) step();
        chk("t3_run", max_run, 24);
        chk("t3_peak_inflight", peak, W + 1);
        chk("t3_drained", q8.size(), 0);
        chk("t3_inflight_end", inf8, 4'h0);

        // Stall for 3 cycles with a result on the output
        for (int j = 0; j < 4; j++) begin
            q8.push_back('{ref_mul(16'(8'h11 * (j + 1)), 16'h00F3, 1'b1, W), 4'(10 + j)});
            send8(8'(8'h11 * (j + 1)), 8'hF3, 1'b1, 4'(10 + j));
        end
        wait_vo8("t4_wait_valid");
        ri8 = 1'b0;
        #1;
        hold_p = p8;
        hold_t = to8;
        hold_if = inf8;
        chk("t4_ready_low", rdy8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_p", p8, hold_p);
            chk("t4_hold_tag", to8, hold_t);
            chk("t4_hold_inflight", inf8, hold_if);
            chk("t4_hold_ready", rdy8, 1'b0);
            chk("t4_hold_valid", vo8, 1'b1);
        end
        ri8 = 1'b1;
        repeat (12) step();
        chk("t4_drained", q8.size(), 0);
        chk("t4_inflight_end", inf8, 4'h0);

        // Flush with 5 in flight; the flushed pairs must never appear
        for (int j = 0; j < 5; j++) send8(8'(j + 3), 8'h05, 1'b0, 4'(j));
        chk("t5_inflight5", inf8, 4'd5);
        v8 = 1'b1; a8 = 8'h44; b8 = 8'h44; s8 = 1'b0; t8 = 4'hF;
        fl8 = 1'b1;
        #1;
        chk("t5_ready_flush", rdy8, 1'b0);
        step();
        fl8 = 1'b0;
        v8 = 1'b0;
        chk("t5_inflight0", inf8, 4'd0);
        chk("t5_valid0", vo8, 1'b0);
        xb = n_xfer;
        repeat (12) step();
        chk("t5_no_flushed_out", n_xfer, xb);

        // Reset mid-stream while a stalled result sits on the output
        ri8 = 1'b0;
        send8(8'h12, 8'h34, 1'b0, 4'h5);
        wait_vo8("t5_wait_valid_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_p", p8, 16'h0);
        chk("t5_rst_tag", to8, 4'h0);
        chk("t5_rst_valid", vo8, 1'b0);
        chk("t5_rst_inflight", inf8, 4'h0);
        chk("t5_rst_ready", rdy8, 1'b1);
        rst_n = 1'b1;
        ri8 = 1'b1;
        xb = n_xfer;
        repeat (12) step();
        chk("t5_no_out_after_rst", n_xfer, xb);

        // WIDTH=4: exhaustive in both modes, streamed back to back
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    q4.push_back('{ref_mul(16'(a), 16'(b), 1'(s), W4) & 16'h00FF, 4'(a)});
                    v4 = 1'b1; a4 = 4'(a); b4 = 4'(b); s4 = 1'(s); t4 = 4'(a);
                    step();
                end
            end
        end
        v4 = 1'b0;
        repeat (10) step();
        chk("t6_drained", q4.size(), 0);
        chk("t6_inflight_end", inf4, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
